pot_adc_responder: RTL and testbench

//  SPI-responder model of the 12-bit potentiometer ADC (AD7476-style frame: 4 leading zeros, then 12 data bits, MSB first).

---
 rtl/pot_adc_responder.sv | 127 ++++++++++++
 tb/tb_pot_adc_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pot_adc_responder.sv
// SPI responder for a 12-bit AD7476-style pot ADC: oversamples cs_n/sclk on board_clk, shifts out {zeros, sample}.
// Optional build macro POT_ADC_RAMP_EN replaces the board-supplied sample with an internal per-frame ramp.
module pot_adc_responder #(
    parameter int DATA_BITS   = 12,
    parameter int LEAD_ZEROS  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RAMP_STEP   = 1
) (
    input  logic                 board_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic                 cs_n,
    input  logic                 sclk,
    output logic                 sdata,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int F  = LEAD_ZEROS + DATA_BITS;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_next;
    logic [F-1:0]           shift, shift_next;
    logic [CW-1:0]          bit_cnt, cnt_next;
    logic [DATA_BITS-1:0]   shadow;
    logic                   done_next;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
    logic                   cs_s, sclk_s, cs_d, sclk_d;
    logic                   cs_fall, cs_rise, sclk_fall;

    // Synchronisers flush to the idle-high level so reset never fakes an edge.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_fall = sclk_d & ~sclk_s;

`ifdef POT_ADC_RAMP_EN
    logic unused_inputs;
    assign unused_inputs = ^{sample_in, sample_valid};

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (done_next)
            shadow <= shadow + DATA_BITS'(RAMP_STEP);
    end
`else
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (sample_valid)
            shadow <= sample_in;
    end
`endif

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= cnt_next;
            frame_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift;
        cnt_next   = bit_cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift_next = {{LEAD_ZEROS{1'b0}}, shadow};
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A chip-select release aborts the frame even if an SCLK fall lands in the same cycle.
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (sclk_fall) begin
                    shift_next = {shift[F-2:0], 1'b0};
                    if (bit_cnt == CW'(F - 1)) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next = bit_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                if (cs_rise)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sdata = (state == SHIFT) ? shift[F-1] : 1'b0;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pot_adc_responder.sv
// Scoreboard bench for pot_adc_responder: a master model clocks frames, a monitor checks each frame_done.
module tb_pot_adc_responder;

    localparam int HALF = 6;

    logic        board_clk = 1'b0;
    logic        reset;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        cs_n;
    logic        sclk;
    logic        sdata;
    logic        busy;
    logic        frame_done;

    logic [15:0] exp_q[$];
    logic [31:0] rx_word;
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_count  = 0;
    int          d0;

    pot_adc_responder #(
        .DATA_BITS  (12),
        .LEAD_ZEROS (4),
        .SYNC_STAGES(2),
        .RAMP_STEP  (1)
    ) dut (
        .board_clk   (board_clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .sdata       (sdata),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each frame_done must match the oldest outstanding expected word.
    always @(posedge board_clk) begin
        #2;
        if (frame_done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame_done: got data %0h expected no frame", rx_word[15:0]);
            end else begin
                check("frame_data", {16'h0, rx_word[15:0]}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d expected frames outstanding", exp_q.size());
        $fatal(1);
    end

    task automatic load(input logic [11:0] v);
        @(negedge board_clk);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge board_clk);
        sample_valid = 1'b0;
    endtask

    // Master: sdata is captured at the end of each SCLK high phase, just before the fall.
    task automatic frame(input int nfalls, input bit release_cs);
        cs_n    = 1'b0;
        rx_word = '0;
        repeat (HALF) @(negedge board_clk);
        for (int i = 0; i < nfalls; i++) begin
            rx_word = {rx_word[30:0], sdata};
            sclk    = 1'b0;
            repeat (HALF) @(negedge board_clk);
            sclk    = 1'b1;
            repeat (HALF) @(negedge board_clk);
        end
        if (release_cs) begin
            cs_n = 1'b1;
            repeat (HALF) @(negedge board_clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cs_n         = 1'b1;
        sclk         = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge board_clk);
        check("reset_sdata", sdata, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        repeat (2) @(negedge board_clk);

`ifdef POT_ADC_RAMP_EN
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(16'(n));
            frame(16, 1'b1);
        end
`else
        // Full frame, busy held in DONE until chip select releases.
        load(12'hA5C);
        exp_q.push_back(16'h0A5C);
        frame(16, 1'b0);
        check("busy_in_done", busy, 1);
        cs_n = 1'b1;
        repeat (4) @(negedge board_clk);
        check("busy_after_cs_rise", busy, 0);

        // sample_valid in the cs_fall cycle takes effect on the following frame.
        load(12'h456);
        exp_q.push_back(16'h0456);
        cs_n = 1'b0;
        @(posedge board_clk);
        @(posedge board_clk);
        @(negedge board_clk);
        sample_in    = 12'h123;
        sample_valid = 1'b1;
        @(negedge board_clk);
        sample_valid = 1'b0;
        frame(16, 1'b1);
        exp_q.push_back(16'h0123);
        frame(16, 1'b1);

        // Aborted frame after 7 bits.
        d0 = done_count;
        frame(7, 1'b1);
        check("abort_idle", busy, 0);
        check("abort_no_done", done_count - d0, 0);
        exp_q.push_back(16'h0123);
        frame(16, 1'b1);

        // Over-long CS window: extra bits read zero, one frame_done.
        load(12'h7E1);
        exp_q.push_back(16'h07E1);
        d0 = done_count;
        frame(20, 1'b1);
        check("overrun_frame_bits", rx_word[19:4], 16'h07E1);
        check("overrun_extra_zero", rx_word[3:0], 0);
        check("overrun_one_done", done_count - d0, 1);

        // Asynchronous reset after 9 bits.
        load(12'hFFF);
        frame(9, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_sdata", sdata, 0);
        check("midreset_busy", busy, 0);
        @(negedge board_clk);
        cs_n = 1'b1;
        sclk = 1'b1;
        repeat (2) @(negedge board_clk);
        reset = 1'b0;
        repeat (2) @(negedge board_clk);
        exp_q.push_back(16'h0000);
        frame(16, 1'b1);
        load(12'h9B2);
        exp_q.push_back(16'h09B2);
        frame(16, 1'b1);
`endif

        repeat (10) @(negedge board_clk);
        check("all_frames_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
